bt656_capture_ctrl: RTL and testbench



---
 rtl/bt656_capture_ctrl_if.sv | 28 ++
 rtl/bt656_capture_ctrl.sv | 177 +++++++++++++++++
 tb/tb_bt656_capture_ctrl.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/bt656_capture_ctrl_if.sv
// Byte-stream, lock/capture control and FIFO write signals of the BT.656 capture sequencer.
// master = stream source / FIFO side, slave = bt656_capture_ctrl.
interface bt656_capture_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] bt_data;
  logic                  bt_datavalid;
  logic                  bt_locked;
  logic                  capture_en;
  logic                  fifo_wrfull;
  logic                  fifo_wrreq;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  field_start;
  logic                  field_id;
  logic                  locked;
  logic                  bt_overflow;
  logic                  trs_err;

  modport master (
    output bt_data, bt_datavalid, bt_locked, capture_en, fifo_wrfull,
    input  fifo_wrreq, fifo_data, field_start, field_id, locked, bt_overflow, trs_err
  );

  modport slave (
    input  bt_data, bt_datavalid, bt_locked, capture_en, fifo_wrfull,
    output fifo_wrreq, fifo_data, field_start, field_id, locked, bt_overflow, trs_err
  );
endinterface

// File: rtl/bt656_capture_ctrl.sv
// BT.656 TRS decoder and crop-windowed luma capture sequencer feeding the capture FIFO.
// Optional: define BT656_XY_CHECK_EN to check the XY protection bits P3..P0.
module bt656_capture_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int LINE_BYTES = 1440,
  parameter int CROP_X0    = 0,
  parameter int CROP_W     = 640,
  parameter int CROP_Y0    = 48,
  parameter int CROP_H     = 240
) (
  input logic                 bt_clock,
  input logic                 reset,
  bt656_capture_ctrl_if.slave bus
);
  localparam int BW = $clog2(LINE_BYTES + 1);
  localparam logic [DATA_WIDTH-1:0] BYTE_FF = '1;
  localparam logic [BW-1:0] LAST_B = BW'(LINE_BYTES - 1);
  localparam logic [BW-1:0] X_LO   = BW'(CROP_X0);
  localparam logic [BW-1:0] X_LEN  = BW'(CROP_W);
  localparam logic [10:0]   Y_LO   = 11'(CROP_Y0);
  localparam logic [10:0]   Y_LEN  = 11'(CROP_H);
  localparam logic [10:0]   LINE_MAX = 11'h7FF;

  typedef enum logic [2:0] {S_FF, S_00A, S_00B, S_XY, S_ACTIVE, S_BLANK} state_t;

  state_t                state_q, state_d;
  logic [BW-1:0]         b_q, b_d;
  logic [10:0]           line_q, line_d;
  logic                  vbl_q, vbl_d;
  logic                  capturing_q, capturing_d;
  logic                  drop_q, drop_d;
  logic                  locked_q, locked_d;
  logic                  overflow_q, overflow_d;
  logic                  field_id_q, field_id_d;
  logic                  field_start_q, field_start_d;
  logic                  trs_err_q, trs_err_d;
  logic                  wrreq_q, wrreq_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  logic [3:0]    xy_hi;
  logic          xy_f, xy_v, xy_h, xy_bad;
  logic          fs, qual;
  logic [BW-1:0] x_rel;
  logic [10:0]   y_rel;

  assign xy_hi = bus.bt_data[DATA_WIDTH-1 -: 4];
  assign xy_f  = xy_hi[2];
  assign xy_v  = xy_hi[1];
  assign xy_h  = xy_hi[0];
`ifdef BT656_XY_CHECK_EN
  logic [3:0] xy_p;
  assign xy_p   = bus.bt_data[DATA_WIDTH-5 -: 4];
  assign xy_bad = !xy_hi[3] ||
                  (xy_p != {xy_v ^ xy_h, xy_f ^ xy_h, xy_f ^ xy_v, xy_f ^ xy_v ^ xy_h});
`else
  assign xy_bad = !xy_hi[3];
`endif

  // Offsets wrap to large values below the window start, so one compare covers both bounds.
  assign x_rel = (b_q >> 1) - X_LO;
  assign y_rel = line_q - Y_LO;
  assign qual  = (state_q == S_ACTIVE) && bus.bt_datavalid && b_q[0] &&
                 (x_rel < X_LEN) && (y_rel < Y_LEN) && capturing_q && !drop_q;

  always_comb begin
    state_d       = state_q;
    b_d           = b_q;
    line_d        = line_q;
    vbl_d         = vbl_q;
    capturing_d   = capturing_q;
    drop_d        = drop_q;
    locked_d      = locked_q;
    overflow_d    = overflow_q;
    field_id_d    = field_id_q;
    data_d        = data_q;
    field_start_d = 1'b0;
    trs_err_d     = 1'b0;
    wrreq_d       = 1'b0;
    fs            = 1'b0;
    if (bus.bt_datavalid) begin
      case (state_q)
        S_FF:  if (bus.bt_data == BYTE_FF) state_d = S_00A;
        S_00A: state_d = (bus.bt_data == '0) ? S_00B : S_FF;
        S_00B: state_d = (bus.bt_data == '0) ? S_XY : S_FF;
        S_XY: begin
          state_d = S_FF;
          if (xy_bad) begin
            trs_err_d = 1'b1;
            locked_d  = 1'b0;
          end else if (xy_h) begin
            if (xy_v) vbl_d = 1'b1;
            else if (line_q != LINE_MAX) line_d = line_q + 11'd1;
          end else if (xy_v) begin
            state_d = S_BLANK;
            b_d     = '0;
            vbl_d   = 1'b1;
          end else begin
            state_d = S_ACTIVE;
            b_d     = '0;
            if (vbl_q) begin
              fs     = 1'b1;
              vbl_d  = 1'b0;
              line_d = '0;
              if (!xy_f) locked_d = 1'b1;
            end
          end
        end
        S_ACTIVE, S_BLANK: begin
          if (b_q == LAST_B) state_d = S_FF;
          else b_d = b_q + BW'(1);
        end
        default: state_d = S_FF;
      endcase
      if (qual) begin
        if (bus.fifo_wrfull) begin
          drop_d     = 1'b1;
          overflow_d = 1'b1;
        end else begin
          wrreq_d = 1'b1;
          data_d  = bus.bt_data;
        end
      end
    end
    // Decoder lock loss overrides a same-cycle field-0 lock acquisition.
    if (!bus.bt_locked) locked_d = 1'b0;
    if (fs) begin
      capturing_d = bus.capture_en & locked_d;
      if (bus.capture_en & locked_d) begin
        field_start_d = 1'b1;
        field_id_d    = xy_f;
        drop_d        = 1'b0;
      end
      if (!bus.capture_en) overflow_d = 1'b0;
    end
    if (!locked_d) capturing_d = 1'b0;
  end

  always_ff @(posedge bt_clock or posedge reset) begin
    if (reset) begin
      state_q       <= S_FF;
      b_q           <= '0;
      line_q        <= '0;
      vbl_q         <= 1'b0;
      capturing_q   <= 1'b0;
      drop_q        <= 1'b0;
      locked_q      <= 1'b0;
      overflow_q    <= 1'b0;
      field_id_q    <= 1'b0;
      field_start_q <= 1'b0;
      trs_err_q     <= 1'b0;
      wrreq_q       <= 1'b0;
      data_q        <= '0;
    end else begin
      state_q       <= state_d;
      b_q           <= b_d;
      line_q        <= line_d;
      vbl_q         <= vbl_d;
      capturing_q   <= capturing_d;
      drop_q        <= drop_d;
      locked_q      <= locked_d;
      overflow_q    <= overflow_d;
      field_id_q    <= field_id_d;
      field_start_q <= field_start_d;
      trs_err_q     <= trs_err_d;
      wrreq_q       <= wrreq_d;
      data_q        <= data_d;
    end
  end

  assign bus.fifo_wrreq  = wrreq_q;
  assign bus.fifo_data   = data_q;
  assign bus.field_start = field_start_q;
  assign bus.field_id    = field_id_q;
  assign bus.locked      = locked_q;
  assign bus.bt_overflow = overflow_q;
  assign bus.trs_err     = trs_err_q;
endmodule

// File: tb/tb_bt656_capture_ctrl.sv
// Scoreboard bench for bt656_capture_ctrl on a reduced raster (16-byte lines, 2 blank + 6 active lines per field).
module tb_bt656_capture_ctrl;
  localparam int DW = 8, LB = 16, CX0 = 2, CW = 4, CY0 = 1, CH = 3, N_ACT = 6;

  logic bt_clock = 1'b0;
  logic reset;
  always #5 bt_clock = ~bt_clock;

  bt656_capture_ctrl_if #(.DATA_WIDTH(DW)) bus ();

  bt656_capture_ctrl #(
    .DATA_WIDTH(DW), .LINE_BYTES(LB), .CROP_X0(CX0), .CROP_W(CW), .CROP_Y0(CY0), .CROP_H(CH)
  ) dut (
    .bt_clock(bt_clock),
    .reset   (reset),
    .bus     (bus)
  );

  int total = 0, bad = 0;
  int wr_cnt = 0, fs_cnt = 0, te_cnt = 0;
  int cyc = 0, fld_n = 0, te0;
  bit gap_mode = 1'b0;
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] xy_byte(input bit f, input bit v, input bit h);
    return {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h};
  endfunction

  // Scoreboard consumer: every FIFO write must match the oldest expected luma byte.
  always @(negedge bt_clock) begin
    logic [7:0] e;
    if (!reset) begin
      if (bus.fifo_wrreq) begin
        wr_cnt++;
        if (exp_q.size() == 0) chk("wr_unexp", {24'd0, bus.fifo_data}, 32'hFFFF_FFFF);
        else begin
          e = exp_q.pop_front();
          chk("wr_data", {24'd0, bus.fifo_data}, {24'd0, e});
        end
      end
      if (bus.field_start) fs_cnt++;
      if (bus.trs_err) te_cnt++;
    end
  end

  task automatic drive(input logic [7:0] d, input bit full);
    if (gap_mode && (cyc % 3 == 2)) begin
      @(negedge bt_clock);
      bus.bt_datavalid = 1'b0;
      bus.bt_data      = 8'hFF;
      bus.fifo_wrfull  = 1'b0;
      cyc++;
    end
    @(negedge bt_clock);
    bus.bt_datavalid = 1'b1;
    bus.bt_data      = d;
    bus.fifo_wrfull  = full;
    cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge bt_clock);
      bus.bt_datavalid = 1'b0;
      bus.fifo_wrfull  = 1'b0;
    end
  endtask

  task automatic trs(input bit f, input bit v, input bit h, input bit corrupt);
    drive(8'hFF, 1'b0);
    drive(8'h00, 1'b0);
    drive(8'h00, 1'b0);
    drive(xy_byte(f, v, h) ^ {7'd0, corrupt}, 1'b0);
  endtask

  task automatic hblank();
    repeat (2) begin
      drive(8'h80, 1'b0);
      drive(8'h10, 1'b0);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_wrreq"}, 32'(bus.fifo_wrreq), 0);
    chk({tag, "_data"},  32'(bus.fifo_data), 0);
    chk({tag, "_fs"},    32'(bus.field_start), 0);
    chk({tag, "_fid"},   32'(bus.field_id), 0);
    chk({tag, "_lock"},  32'(bus.locked), 0);
    chk({tag, "_ovf"},   32'(bus.bt_overflow), 0);
    chk({tag, "_terr"},  32'(bus.trs_err), 0);
  endtask

  // One field: 2 vertical-blank lines then N_ACT active lines; optional full pulse, XY corruption,
  // capture_en drop, or reset, each placed at an active line index (-1 = none).
  task automatic run_field(input bit f, input bit cap, input int exp_fs, input int exp_wr,
                           input int full_k, input int full_x, input int bad_k,
                           input int en_off_k, input int rst_k);
    int fs0 = fs_cnt;
    int wr0 = wr_cnt;
    bit cap_now = cap;
    bit drop = 1'b0;
    bit q, full;
    logic [7:0] d;
    for (int l = 0; l < 2; l++) begin
      trs(f, 1'b1, 1'b1, 1'b0);
      hblank();
      trs(f, 1'b1, 1'b0, 1'b0);
      for (int b = 0; b < LB; b++) drive(b[0] ? 8'h10 : 8'h80, 1'b0);
    end
    for (int k = 0; k < N_ACT; k++) begin
      if (k == en_off_k) bus.capture_en = 1'b0;
      trs(f, 1'b0, 1'b1, k == bad_k);
`ifdef BT656_XY_CHECK_EN
      if (k == bad_k) cap_now = 1'b0;
`endif
      hblank();
      trs(f, 1'b0, 1'b0, 1'b0);
      for (int b = 0; b < LB; b++) begin
        if (k == rst_k && b == 6) begin
          @(negedge bt_clock);
          #2 reset = 1'b1;
          #1 check_zero("rst_mid");
          @(negedge bt_clock);
          bus.bt_datavalid = 1'b0;
          reset = 1'b0;
          cap_now = 1'b0;
        end
        full = (k == full_k) && (b == 2 * full_x + 1);
        q = cap_now && !drop && (b % 2 == 1) && (b / 2 >= CX0) && (b / 2 < CX0 + CW) &&
            (k >= CY0) && (k < CY0 + CH);
        d = 8'(32 + ((fld_n * 37 + k * 16 + b) % 192));
        if (q && full) drop = 1'b1;
        else if (q) exp_q.push_back(d);
        drive(d, full);
      end
    end
    idle(3);
    chk("fs_n", fs_cnt - fs0, exp_fs);
    chk("wr_n", wr_cnt - wr0, exp_wr);
    chk("q_left", exp_q.size(), 0);
    if (exp_fs > 0 && rst_k < 0) chk("field_id", 32'(bus.field_id), 32'(f));
    exp_q.delete();
    fld_n++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: sim time limit reached, summary not reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.bt_data = '0;
    bus.bt_datavalid = 1'b0;
    bus.bt_locked = 1'b1;
    bus.capture_en = 1'b1;
    bus.fifo_wrfull = 1'b0;
    repeat (3) @(negedge bt_clock);
    check_zero("rst");
    reset = 1'b0;

    run_field(1'b1, 1'b0, 0, 0, -1, -1, -1, -1, -1);
    chk("locked_pre", 32'(bus.locked), 0);
    run_field(1'b0, 1'b1, 1, 12, -1, -1, -1, -1, -1);
    chk("locked", 32'(bus.locked), 1);
    run_field(1'b1, 1'b1, 1, 12, -1, -1, -1, -1, -1);

    run_field(1'b0, 1'b1, 1, 5, 2, 3, -1, -1, -1);
    chk("ovf_set", 32'(bus.bt_overflow), 1);
    run_field(1'b1, 1'b1, 1, 12, -1, -1, -1, -1, -1);
    chk("ovf_sticky", 32'(bus.bt_overflow), 1);

    te0 = te_cnt;
`ifdef BT656_XY_CHECK_EN
    run_field(1'b0, 1'b1, 1, 8, -1, -1, 3, -1, -1);
    chk("trs_err_n", te_cnt - te0, 1);
    chk("locked_err", 32'(bus.locked), 0);
    run_field(1'b1, 1'b0, 0, 0, -1, -1, -1, -1, -1);
    run_field(1'b0, 1'b1, 1, 12, -1, -1, -1, -1, -1);
`else
    run_field(1'b0, 1'b1, 1, 12, -1, -1, 3, -1, -1);
    chk("trs_err_n", te_cnt - te0, 0);
    chk("locked_err", 32'(bus.locked), 1);
    run_field(1'b1, 1'b1, 1, 12, -1, -1, -1, -1, -1);
    run_field(1'b0, 1'b1, 1, 12, -1, -1, -1, -1, -1);
`endif
    chk("relock", 32'(bus.locked), 1);

    run_field(1'b1, 1'b1, 1, 12, -1, -1, -1, 2, -1);
    chk("ovf_keep", 32'(bus.bt_overflow), 1);
    run_field(1'b0, 1'b0, 0, 0, -1, -1, -1, -1, -1);
    chk("ovf_clr", 32'(bus.bt_overflow), 0);

    bus.capture_en = 1'b1;
    gap_mode = 1'b1;
    run_field(1'b1, 1'b1, 1, 12, -1, -1, -1, -1, -1);
    run_field(1'b0, 1'b1, 1, 12, -1, -1, -1, -1, -1);
    gap_mode = 1'b0;

    run_field(1'b1, 1'b1, 1, 5, -1, -1, -1, -1, 2);
    chk("locked_rst", 32'(bus.locked), 0);
    run_field(1'b1, 1'b0, 0, 0, -1, -1, -1, -1, -1);
    run_field(1'b0, 1'b1, 1, 12, -1, -1, -1, -1, -1);
    chk("locked_post", 32'(bus.locked), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
